serial_bus_master_p: RTL

Parametrised next-generation master for the single-wire serial bus. It latches one read or write command from the local side, requests the arbiter, and shifts the address and data LSB-first over B_BUS_OUT/B_BUS_IN. It adds configurable address/data widths, acknowledge timeout with bounded retry, an error report, and split/resume of reads when grant is withdrawn. It sits between a local controller and the shared arbiter/slave bus, replacing the fixed 16/8-bit master.

---
 rtl/serial_bus_pkg.sv | 29 ++
 rtl/counter.sv | 23 ++
 rtl/serial_bus_master_p.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the parametrised single-wire serial bus master.
// Holds the FSM state encoding, the read/write encoding and a counter-width helper.
package serial_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        ADDR,
        ACKA,
        WDATA,
        ACKW,
        RDATA,
        SPLIT,
        DONE,
        ERR
    } sbm_state_t;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int sbm_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with a synchronous clear and an increment enable.
// Clear wins over increment; the asynchronous reset clears to zero.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             rst,
    input  logic             incr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count <= '0;
        end else if (rst) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_bus_master_p.sv
// Single-wire serial bus master: arbitrates, shifts address/data LSB-first, waits for
// acknowledge with bounded retry, and splits reads across grant withdrawal.
module serial_bus_master_p
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 3,
    parameter int MAX_RETRY   = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              M_EXECUTE,
    input  logic              M_RW,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [DATA_W-1:0] M_DIN,
    output logic [DATA_W-1:0] M_DOUT,
    output logic              M_DVALID,
    output logic              M_ERR,
    output logic              M_BSY,
    output logic              B_REQ,
    input  logic              B_GRANT,
    output logic              B_UTIL,
    output logic              B_RW,
    output logic              A_ADD,
    output logic              B_BUS_OUT,
    input  logic              B_BUS_IN,
    input  logic              B_ACK,
    output logic              B_DONE
);

    localparam int IDX_W = sbm_width((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int TO_W  = sbm_width(ACK_TIMEOUT);
    localparam int RT_W  = sbm_width(MAX_RETRY + 1);

    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_W - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [RT_W-1:0]  RT_MAX    = RT_W'(MAX_RETRY);

    sbm_state_t        state;
    sbm_state_t        nxt;
    logic              rw_sh;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] rdata_sh;
    logic [DATA_W-1:0] rdata_nxt;
    logic [DATA_W-1:0] bit_mask;
    logic [RT_W-1:0]   retry;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic              idx_clr;
    logic              idx_inc;
    logic              to_clr;
    logic              to_inc;
    logic              rt_inc;
    logic              rd_cap;
    logic              ack_expired;
    logic              accept;
    logic              addr_bit;
    logic              data_bit;

    counter #(.WIDTH(IDX_W)) u_idx (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .rst   (idx_clr),
        .incr  (idx_inc),
        .count (idx)
    );

    counter #(.WIDTH(TO_W)) u_timeout (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .rst   (to_clr),
        .incr  (to_inc),
        .count (to_cnt)
    );

    assign accept = (state == IDLE) && M_EXECUTE;

    always_comb begin
        nxt         = state;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        to_clr      = 1'b1;
        to_inc      = 1'b0;
        rt_inc      = 1'b0;
        rd_cap      = 1'b0;
        ack_expired = (to_cnt == TO_LAST);
        case (state)
            IDLE: begin
                idx_clr = 1'b1;
                if (M_EXECUTE) nxt = REQ;
            end
            REQ: begin
                idx_clr = 1'b1;
                if (B_GRANT) nxt = ADDR;
            end
            ADDR, WDATA: begin
                // Losing grant mid-shift restarts the whole transfer from address bit 0.
                if (!B_GRANT) begin
                    nxt     = REQ;
                    idx_clr = 1'b1;
                end else if (state == ADDR && idx == ADDR_LAST) begin
                    nxt     = ACKA;
                    idx_clr = 1'b1;
                end else if (state == WDATA && idx == DATA_LAST) begin
                    nxt     = ACKW;
                    idx_clr = 1'b1;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            ACKA, ACKW: begin
                to_clr = 1'b0;
                if (B_ACK) begin
                    idx_clr = 1'b1;
                    if (state == ACKW)       nxt = DONE;
                    else if (rw_sh == BUS_WR) nxt = WDATA;
                    else                     nxt = RDATA;
                end else if (ack_expired) begin
                    to_clr = 1'b1;
                    if (retry < RT_MAX) begin
                        rt_inc = 1'b1;
                        nxt    = REQ;
                    end else begin
                        nxt = ERR;
                    end
                end else begin
                    to_inc = 1'b1;
                end
            end
            RDATA, SPLIT: begin
                // The bit at the held index is captured on the edge where grant is back.
                if (!B_GRANT) begin
                    nxt = SPLIT;
                end else begin
                    rd_cap = 1'b1;
                    if (idx == DATA_LAST) begin
                        nxt     = DONE;
                        idx_clr = 1'b1;
                    end else begin
                        nxt     = RDATA;
                        idx_inc = 1'b1;
                    end
                end
            end
            default: begin
                idx_clr = 1'b1;
                nxt     = IDLE;
            end
        endcase

        idx_nxt   = idx_clr ? '0 : (idx_inc ? idx + 1'b1 : idx);
        bit_mask  = DATA_W'(1) << idx;
        rdata_nxt = B_BUS_IN ? (rdata_sh | bit_mask) : (rdata_sh & ~bit_mask);
        addr_bit  = 1'(addr_sh >> idx_nxt);
        data_bit  = 1'(data_sh >> idx_nxt);
    end

    // State, shadow registers and every output are registered from the next state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            rw_sh     <= BUS_RD;
            addr_sh   <= '0;
            data_sh   <= '0;
            rdata_sh  <= '0;
            retry     <= '0;
            M_DOUT    <= '0;
            M_DVALID  <= 1'b0;
            M_ERR     <= 1'b0;
            M_BSY     <= 1'b0;
            B_REQ     <= 1'b0;
            B_UTIL    <= 1'b0;
            B_RW      <= 1'b0;
            A_ADD     <= 1'b0;
            B_BUS_OUT <= 1'b0;
            B_DONE    <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                rw_sh   <= M_RW;
                addr_sh <= M_ADDR;
                data_sh <= M_DIN;
                retry   <= '0;
            end else if (rt_inc) begin
                retry <= retry + 1'b1;
            end
            if (rd_cap) begin
                rdata_sh <= rdata_nxt;
            end
            if (rd_cap && nxt == DONE) begin
                M_DOUT <= rdata_nxt;
            end
            M_BSY     <= (nxt != IDLE);
            B_REQ     <= nxt inside {REQ, ADDR, ACKA, WDATA, ACKW, RDATA, SPLIT};
            B_UTIL    <= nxt inside {ADDR, ACKA, WDATA, ACKW, RDATA};
            B_RW      <= rw_sh && (nxt inside {ADDR, ACKA, WDATA, ACKW, RDATA});
            A_ADD     <= (nxt == ADDR);
            B_BUS_OUT <= (nxt == ADDR) ? addr_bit : ((nxt == WDATA) ? data_bit : 1'b0);
            M_DVALID  <= (nxt == DONE);
            M_ERR     <= (nxt == ERR);
            B_DONE    <= (nxt == DONE) || (nxt == ERR);
        end
    end

endmodule
